// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to a synchronous
// instruction memory with 1-cycle latency, and buffers returned words for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  output logic [31:0] fetch_count
);

  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]            fetch_pc_reg, fetch_pc_next;
  logic                   inflight_reg, inflight_next;
  logic [31:0]            inflight_pc_reg, inflight_pc_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [PTR_W-1:0]       head_reg, head_next;
  logic [PTR_W-1:0]       tail_reg, tail_next;
  logic [31:0]            fetch_count_reg, fetch_count_next;
  logic                   pop, push, pop_commit;
  logic [31:0]            occupancy, limit;
  logic [DEPTH-1:0][63:0] entry_bus;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ins_valid = (count_reg != '0);
  assign pop       = ins_valid & ins_ready;

  // Outstanding slots (buffered + in flight, less the word leaving now) must
  // leave room for the response of a request issued this cycle.
  assign occupancy = 32'(count_reg) + 32'(inflight_reg);
  assign limit     = 32'(DEPTH) + 32'(pop);
  assign imem_req  = !rst && !redirect_en && (occupancy < limit);
  assign imem_addr = fetch_pc_reg;

  // A redirect squashes the response arriving in the same cycle and the
  // concurrent pop; nothing is left in flight afterwards, so no later drop.
  assign push       = inflight_reg & !redirect_en;
  assign pop_commit = pop & !redirect_en;

  assign ins_out     = ins_valid ? entry_bus[head_reg][31:0]  : NOP;
  assign ins_pc      = ins_valid ? entry_bus[head_reg][63:32] : 32'h0;
  assign fetch_count = fetch_count_reg;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_next    = 1'b0;
    inflight_pc_next = inflight_pc_reg;
    count_next       = count_reg + CNT_W'(push) - CNT_W'(pop_commit);
    head_next        = pop_commit ? ptr_inc(head_reg) : head_reg;
    tail_next        = push ? ptr_inc(tail_reg) : tail_reg;
    fetch_count_next = fetch_count_reg + 32'(pop_commit);
    if (redirect_en) begin
      fetch_pc_next = redirect_pc & ~32'h3;
      count_next    = '0;
      head_next     = '0;
      tail_next     = '0;
    end else if (imem_req) begin
      fetch_pc_next    = fetch_pc_reg + 32'd4;
      inflight_next    = 1'b1;
      inflight_pc_next = fetch_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
      count_reg       <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      fetch_count_reg <= 32'h0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      count_reg       <= count_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [63:0] entry_reg;
      always_ff @(posedge clk) begin
        if (!rst && push && (tail_reg == PTR_W'(gi))) begin
          entry_reg <= {inflight_pc_reg, imem_rdata};
        end
      end
      assign entry_bus[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table for directed scenarios, then
// randomized traffic checked against a stream-level model of delivered PCs.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_out(ins_out), .ins_pc(ins_pc), .fetch_count(fetch_count)
  );

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  always_ff @(posedge clk) begin
    imem_rdata <= imem_req ? mem_fn(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        chk;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rdy, input logic rd,
                              input logic [31:0] rpc, input logic chk,
                              input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc,
                              input logic [31:0] cnt);
    vec_t e;
    e.rst = r; e.ready = rdy; e.redir = rd; e.rpc = rpc; e.chk = chk;
    e.e_req = req; e.e_addr = addr; e.e_valid = v; e.e_pc = pc; e.e_cnt = cnt;
    vecs.push_back(e);
  endfunction

  function automatic void add_rst();
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic void add_run(input logic rdy, input logic req, input logic [31:0] addr,
                                  input logic v, input logic [31:0] pc, input logic [31:0] cnt);
    add(1'b0, rdy, 1'b0, 32'h0, 1'b1, req, addr, v, pc, cnt);
  endfunction

  function automatic void add_redir(input logic rdy, input logic [31:0] rpc, input logic [31:0] addr,
                                    input logic v, input logic [31:0] pc, input logic [31:0] cnt);
    add(1'b0, rdy, 1'b1, rpc, 1'b1, 1'b0, addr, v, pc, cnt);
  endfunction

  // Random-phase model state
  logic [31:0] exp_next, exp_cnt, evt_pc, hold_pc, hold_out;
  logic        hold;
  int          since_evt;

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0; ins_ready = 1'b0;

    // Steady stream with ins_ready held high
    add_rst();
    for (int k = 1; k <= 13; k++) begin
      add_run(1'b1, 1'b1, 32'(4 * (k - 1)), (k >= 3),
              (k >= 3) ? 32'(4 * (k - 3)) : 32'h0, (k >= 3) ? 32'(k - 3) : 32'h0);
    end
    // Decode stalls for 5 cycles starting at cycle 3
    add_rst();
    add_run(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0);
    for (int k = 0; k < 5; k++) add_run(1'b0, 1'b0, 32'h8, 1'b1, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 32'd1);
    add_run(1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'd2);
    add_run(1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'd3);
    // Redirect while one entry is buffered and its successor returns
    add_rst();
    add_run(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0);
    add_redir(1'b0, 32'h103, 32'h8, 1'b1, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'd0);
    add_run(1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'd0);
    add_run(1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 32'd0);
    add_run(1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 32'd1);
    // Redirect with a full buffer
    add_rst();
    add_run(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0);
    add_run(1'b0, 1'b0, 32'h8, 1'b1, 32'h0, 32'd0);
    add_redir(1'b0, 32'h103, 32'h8, 1'b1, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'd0);
    add_run(1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'd0);
    add_run(1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 32'd0);
    // Redirect with pop, back-to-back redirect, wrap, reset with redirect
    add_rst();
    add_run(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'd0);
    add_redir(1'b1, 32'h300, 32'hC,   1'b1, 32'h4, 32'd1);
    add_redir(1'b1, 32'h200, 32'h300, 1'b0, 32'h0, 32'd1);
    add_run(1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'd1);
    add_run(1'b1, 1'b1, 32'h204, 1'b0, 32'h0,   32'd1);
    add_run(1'b1, 1'b1, 32'h208, 1'b1, 32'h200, 32'd1);
    add_run(1'b1, 1'b1, 32'h20C, 1'b1, 32'h204, 32'd2);
    add_redir(1'b1, 32'hFFFF_FFFF, 32'h210, 1'b1, 32'h208, 32'd3);
    add_run(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'd3);
    add_run(1'b1, 1'b1, 32'h0,         1'b0, 32'h0,         32'd3);
    add_run(1'b1, 1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC, 32'd3);
    add_run(1'b1, 1'b1, 32'h8,         1'b1, 32'h0,         32'd4);
    add(1'b1, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'hC, 1'b1, 32'h4, 32'd5);
    add_run(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0);
    add_run(1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; ins_ready = vecs[i].ready;
      redirect_en = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      $display("vec %0d rst=%0b rdy=%0b redir=%0b req=%0b addr=%h valid=%0b pc=%h ins=%h cnt=%0d",
               i, rst, ins_ready, redirect_en, imem_req, imem_addr, ins_valid, ins_pc, ins_out, fetch_count);
      if (vecs[i].chk) begin
        check("imem_req", i, {31'd0, imem_req}, {31'd0, vecs[i].e_req});
        check("imem_addr", i, imem_addr, vecs[i].e_addr);
        check("ins_valid", i, {31'd0, ins_valid}, {31'd0, vecs[i].e_valid});
        check("ins_pc", i, ins_pc, vecs[i].e_pc);
        check("ins_out", i, ins_out, vecs[i].e_valid ? mem_fn(vecs[i].e_pc) : NOP);
        check("fetch_count", i, fetch_count, vecs[i].e_cnt);
      end
    end

    // Randomized traffic against the delivered-stream model
    exp_next = RESET_PC; exp_cnt = 32'h0; evt_pc = RESET_PC;
    hold = 1'b0; hold_pc = 32'h0; hold_out = 32'h0; since_evt = 100;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst         = (cyc == 0) || ($urandom_range(0, 199) == 0);
      redirect_en = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                 : 32'($urandom);
      ins_ready   = ($urandom_range(0, 9) < 7);
      #1;
      if (rst) begin
        check("rand_req_in_reset", cyc, {31'd0, imem_req}, 32'h0);
      end else begin
        check("rand_fetch_count", cyc, fetch_count, exp_cnt);
        if (redirect_en) check("rand_req_on_redirect", cyc, {31'd0, imem_req}, 32'h0);
        if (!ins_valid) begin
          check("rand_idle_ins", cyc, ins_out, NOP);
          check("rand_idle_pc", cyc, ins_pc, 32'h0);
        end else begin
          check("rand_ins_data", cyc, ins_out, mem_fn(ins_pc));
        end
        if (since_evt == 1 || since_evt == 2)
          check("rand_valid_blank", cyc, {31'd0, ins_valid}, 32'h0);
        if (since_evt == 3) begin
          check("rand_valid_latency", cyc, {31'd0, ins_valid}, 32'h1);
          check("rand_target_pc", cyc, ins_pc, evt_pc);
        end
        if (hold) begin
          check("rand_hold_valid", cyc, {31'd0, ins_valid}, 32'h1);
          check("rand_hold_pc", cyc, ins_pc, hold_pc);
          check("rand_hold_ins", cyc, ins_out, hold_out);
        end
        if (ins_valid && ins_ready && !redirect_en) begin
          check("rand_stream_pc", cyc, ins_pc, exp_next);
          $display("txn cyc=%0d pc=%h ins=%h count=%0d", cyc, ins_pc, ins_out, fetch_count);
        end
      end
      hold     = !rst && !redirect_en && ins_valid && !ins_ready;
      hold_pc  = ins_pc;
      hold_out = ins_out;
      if (rst) begin
        exp_next = RESET_PC; exp_cnt = 32'h0; evt_pc = RESET_PC; since_evt = 0;
      end else if (redirect_en) begin
        exp_next = redirect_pc & ~32'h3; evt_pc = redirect_pc & ~32'h3; since_evt = 0;
      end else if (ins_valid && ins_ready) begin
        exp_next = exp_next + 32'd4;
        exp_cnt  = exp_cnt + 32'd1;
      end
      if (since_evt < 100) since_evt++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
